// File: rtl/ex_stage_dual.sv
// Dual-lane execute stage with EX/MEM pipeline register for the 8-bit dual-issue core.
// Define EX_FWD_EN to build the operand forwarding network; otherwise operands come straight from readdata.
module ex_stage_dual (
   input  logic       clk,
   input  logic       reset,
   input  logic       stall,
   input  logic       flush,
   input  logic       memwrite_1,
   input  logic       memread_1,
   input  logic       memtoreg_1,
   input  logic       Alusrc_1,
   input  logic       regwrite_1,
   input  logic [1:0] Aluop_1,
   input  logic [2:0] func3_1,
   input  logic [6:0] func7_1,
   input  logic [4:0] rd_1,
   input  logic [4:0] rs1_1,
   input  logic [4:0] rs2_1,
   input  logic [7:0] readdata1_1,
   input  logic [7:0] readdata2_1,
   input  logic [7:0] imm_1,
   input  logic       wb_regwrite_1,
   input  logic [4:0] wb_rd_1,
   input  logic [7:0] wb_data_1,
   input  logic       memwrite_2,
   input  logic       memread_2,
   input  logic       memtoreg_2,
   input  logic       Alusrc_2,
   input  logic       regwrite_2,
   input  logic [1:0] Aluop_2,
   input  logic [2:0] func3_2,
   input  logic [6:0] func7_2,
   input  logic [4:0] rd_2,
   input  logic [4:0] rs1_2,
   input  logic [4:0] rs2_2,
   input  logic [7:0] readdata1_2,
   input  logic [7:0] readdata2_2,
   input  logic [7:0] imm_2,
   input  logic       wb_regwrite_2,
   input  logic [4:0] wb_rd_2,
   input  logic [7:0] wb_data_2,
   output logic [7:0] alu_result_1_out,
   output logic [7:0] store_data_1_out,
   output logic       zero_1_out,
   output logic [4:0] rd_1_out,
   output logic       memwrite_1_out,
   output logic       memread_1_out,
   output logic       memtoreg_1_out,
   output logic       regwrite_1_out,
   output logic [7:0] alu_result_2_out,
   output logic [7:0] store_data_2_out,
   output logic       zero_2_out,
   output logic [4:0] rd_2_out,
   output logic       memwrite_2_out,
   output logic       memread_2_out,
   output logic       memtoreg_2_out,
   output logic       regwrite_2_out
);

   function automatic logic [7:0] alu_op(input logic [1:0] aluop, input logic [2:0] f3,
                                         input logic alt, input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      r = '0;
      case (aluop)
         2'b00: r = a + b;
         2'b01: r = a - b;
         default: begin
            case (f3)
               3'b000: r = (aluop == 2'b10 && alt) ? a - b : a + b;
               3'b001: r = a << b[2:0];
               3'b010: r = ($signed(a) < $signed(b)) ? 8'h01 : 8'h00;
               3'b100: r = a ^ b;
               3'b101: begin
                  // kept as its own statement so the shift stays arithmetic
                  if (alt) r = $signed(a) >>> b[2:0];
                  else     r = a >> b[2:0];
               end
               3'b110: r = a | b;
               3'b111: r = a & b;
               default: r = '0;
            endcase
         end
      endcase
      return r;
   endfunction

   logic [7:0] src1_1, src2_1, src1_2, src2_2;
   logic [7:0] opb_1, opb_2, alu_1, alu_2;

   logic unused_func7;
   assign unused_func7 = ^{func7_1[6], func7_1[4:0], func7_2[6], func7_2[4:0]};

`ifdef EX_FWD_EN
   // Youngest producer first: EX/MEM lane 2, EX/MEM lane 1, MEM/WB lane 2, MEM/WB lane 1.
   function automatic logic [7:0] fwd_sel(
      input logic [4:0] r, input logic [7:0] rf,
      input logic e2v, input logic [4:0] e2r, input logic [7:0] e2d,
      input logic e1v, input logic [4:0] e1r, input logic [7:0] e1d,
      input logic w2v, input logic [4:0] w2r, input logic [7:0] w2d,
      input logic w1v, input logic [4:0] w1r, input logic [7:0] w1d);
      logic [7:0] v;
      v = rf;
      if (r != 5'd0) begin
         if (e2v && e2r == r)      v = e2d;
         else if (e1v && e1r == r) v = e1d;
         else if (w2v && w2r == r) v = w2d;
         else if (w1v && w1r == r) v = w1d;
      end
      return v;
   endfunction

   // Loads sitting in EX/MEM have no data yet, so they never forward from there.
   logic ex_v_1, ex_v_2;
   assign ex_v_1 = regwrite_1_out & ~memtoreg_1_out;
   assign ex_v_2 = regwrite_2_out & ~memtoreg_2_out;

   assign src1_1 = fwd_sel(rs1_1, readdata1_1, ex_v_2, rd_2_out, alu_result_2_out,
                           ex_v_1, rd_1_out, alu_result_1_out,
                           wb_regwrite_2, wb_rd_2, wb_data_2, wb_regwrite_1, wb_rd_1, wb_data_1);
   assign src2_1 = fwd_sel(rs2_1, readdata2_1, ex_v_2, rd_2_out, alu_result_2_out,
                           ex_v_1, rd_1_out, alu_result_1_out,
                           wb_regwrite_2, wb_rd_2, wb_data_2, wb_regwrite_1, wb_rd_1, wb_data_1);
   assign src1_2 = fwd_sel(rs1_2, readdata1_2, ex_v_2, rd_2_out, alu_result_2_out,
                           ex_v_1, rd_1_out, alu_result_1_out,
                           wb_regwrite_2, wb_rd_2, wb_data_2, wb_regwrite_1, wb_rd_1, wb_data_1);
   assign src2_2 = fwd_sel(rs2_2, readdata2_2, ex_v_2, rd_2_out, alu_result_2_out,
                           ex_v_1, rd_1_out, alu_result_1_out,
                           wb_regwrite_2, wb_rd_2, wb_data_2, wb_regwrite_1, wb_rd_1, wb_data_1);
`else
   assign src1_1 = readdata1_1;
   assign src2_1 = readdata2_1;
   assign src1_2 = readdata1_2;
   assign src2_2 = readdata2_2;

   logic unused_fwd;
   assign unused_fwd = ^{rs1_1, rs2_1, rs1_2, rs2_2, wb_regwrite_1, wb_rd_1, wb_data_1,
                         wb_regwrite_2, wb_rd_2, wb_data_2};
`endif

   assign opb_1 = Alusrc_1 ? imm_1 : src2_1;
   assign opb_2 = Alusrc_2 ? imm_2 : src2_2;
   assign alu_1 = alu_op(Aluop_1, func3_1, func7_1[5], src1_1, opb_1);
   assign alu_2 = alu_op(Aluop_2, func3_2, func7_2[5], src1_2, opb_2);

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         alu_result_1_out <= '0;
         store_data_1_out <= '0;
         zero_1_out       <= 1'b0;
         rd_1_out         <= '0;
         memwrite_1_out   <= 1'b0;
         memread_1_out    <= 1'b0;
         memtoreg_1_out   <= 1'b0;
         regwrite_1_out   <= 1'b0;
         alu_result_2_out <= '0;
         store_data_2_out <= '0;
         zero_2_out       <= 1'b0;
         rd_2_out         <= '0;
         memwrite_2_out   <= 1'b0;
         memread_2_out    <= 1'b0;
         memtoreg_2_out   <= 1'b0;
         regwrite_2_out   <= 1'b0;
      end else if (!stall) begin
         alu_result_1_out <= alu_1;
         store_data_1_out <= src2_1;
         zero_1_out       <= (alu_1 == 8'h00);
         rd_1_out         <= rd_1;
         memwrite_1_out   <= memwrite_1;
         memread_1_out    <= memread_1;
         memtoreg_1_out   <= memtoreg_1;
         regwrite_1_out   <= regwrite_1;
         alu_result_2_out <= alu_2;
         store_data_2_out <= src2_2;
         zero_2_out       <= (alu_2 == 8'h00);
         rd_2_out         <= rd_2;
         memwrite_2_out   <= memwrite_2;
         memread_2_out    <= memread_2;
         memtoreg_2_out   <= memtoreg_2;
         regwrite_2_out   <= regwrite_2;
      end
   end

endmodule

// File: doc/ex_stage_dual.md
# ex_stage_dual

Dual-lane execute stage with the EX/MEM pipeline register, directly downstream of the ID/EX register of the 8-bit dual-issue core. Each lane selects forwarded operands, performs an 8-bit ALU operation chosen by Aluop/func3/func7, and registers the result, the store data and the memory/writeback controls for the MEM stage. Stall holds the register; flush inserts a bubble in both lanes.

## Interface

Parameters:
- none (data width fixed at 8, register index at 5)

Ports (n = 1, 2, one set per lane):
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high; clock clk
- stall  in  1  hold EX/MEM contents
- flush  in  1  load a bubble into both lanes
- memwrite_n, memread_n, memtoreg_n, Alusrc_n, regwrite_n  in  1 each  controls from ID/EX
- Aluop_n  in  2  ALU class from ID/EX
- func3_n / func7_n  in  3 / 7  function fields
- rd_n, rs1_n, rs2_n  in  5 each  register indices
- readdata1_n, readdata2_n, imm_n  in  8 each  register-file operands, immediate
- wb_regwrite_n  in  1  MEM/WB writeback enable
- wb_rd_n  in  5  MEM/WB destination
- wb_data_n  in  8  MEM/WB writeback value
- alu_result_n_out  out  8  registered ALU result
- store_data_n_out  out  8  registered forwarded rs2 value
- zero_n_out  out  1  registered (ALU result == 0)
- rd_n_out  out  5  registered destination
- memwrite_n_out, memread_n_out, memtoreg_n_out, regwrite_n_out  out  1 each  registered controls

## Operation

- Operand A = forwarded rs1 value; operand B = imm_n if Alusrc_n else forwarded rs2 value; store_data = forwarded rs2 value.
- Forwarding priority per source index r (first match wins): EX/MEM lane 2, EX/MEM lane 1, MEM/WB lane 2, MEM/WB lane 1, readdata. An EX/MEM match requires regwrite_k_out=1, memtoreg_k_out=0, rd_k_out=r. A MEM/WB match requires wb_regwrite_k=1, wb_rd_k=r. r=0 never matches; value is readdata.
- Same-bundle lane1->lane2 dependences are never forwarded; the decoder does not issue them.
- ALU decode: Aluop 00 -> add; 01 -> sub; 10 (R) -> func3 000 add (sub if func7[5]), 001 sll, 010 slt signed, 100 xor, 101 srl (sra if func7[5]), 110 or, 111 and; 11 (I) -> same with func7 ignored except for 101 (func7[5] selects sra).
- Arithmetic wraps modulo 256; shift amount = B[2:0]; slt result is 8'h01 or 8'h00.
- Register update priority: reset > flush > stall > load.
- Reset: every output 0. Flush: every output 0 (bubble). Stall: every output holds. Otherwise all outputs load the values computed from current inputs.

## Timing

- Latency 1 cycle: inputs sampled at edge k appear on outputs after edge k.
- Forwarding mux and ALU are combinational from current inputs and current EX/MEM outputs.
- Back-to-back dependent ALU ops forward with zero bubbles; load-use needs one stall from the hazard unit. During that stall the EX/MEM load is not forwarded, and the value comes from MEM/WB on the next cycle.
- Reset or flush asserted with stall: reset/flush wins.
- Both lanes writing the same rd: lane 2 is youngest and wins forwarding.

## Configuration

- EX_FWD_EN defined: forwarding network as above.
- EX_FWD_EN undefined: operands are readdata1_n/readdata2_n directly; wb_* inputs unused. Hazard unit stalls for all RAW dependences; all other behaviour is identical.

## Test plan

- Reset held 2 cycles with nonzero inputs -> all outputs 0; deassert, lane1 add 8'h7F+8'h01 -> alu_result_1_out=8'h80, zero_1_out=0.
- Lane1 R-sub 8'h05-8'h05 -> alu_result=8'h00, zero=1. Lane2 sra 8'h80 by 3 -> 8'hF0. Lane2 slt 8'hFF<8'h01 -> 8'h01.
- Cycle k: lane1 writes r3=8'h10, lane2 writes r3=8'h20. Cycle k+1: lane1 reads rs1=r3 with readdata1=8'h00, add imm 1 -> 8'h21 (EX/MEM lane 2 wins).
- EX/MEM holds load to r4 (memtoreg=1) and wb_rd_1=r4, wb_data_1=8'h33 -> consumer sees 8'h33, not the EX/MEM ALU value; rs1=r0 with any matches -> readdata used.
- stall=1 for 3 cycles with changing inputs -> outputs constant. flush=1 with stall=1 -> all outputs 0 next cycle.
- EX_FWD_EN undefined: repeat the r3 case -> result 8'h01 (readdata used).
